alu_seq: RTL and testbench

Parametrised, handshaked successor to the 8-bit combinational datapath ALU. Accepts one operation per valid/ready transfer and registers the result, carry, parity and zero flags. Single-cycle ops have one-cycle latency. An optional iterative unsigned multiply takes W cycles. Sits between the register-file read stage and write-back, so the core can stall on multi-cycle ops.

---
 rtl/alu_pkg.sv | 27 ++
 rtl/alu_mul_iter.sv | 54 +++++
 rtl/alu_seq.sv | 153 +++++++++++++++
 tb/tb_alu_seq.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared types for the handshaked sequential ALU.
//   alu_op_e    - 3-bit opcode set
//   alu_state_e - control FSM states
//   ALU_W_MIN / ALU_W_MAX - legal datapath width range (power of two)
package alu_pkg;

  localparam int ALU_W_MIN = 8;
  localparam int ALU_W_MAX = 32;

  typedef enum logic [2:0] {
    OP_PASS = 3'b000,
    OP_SUB  = 3'b001,
    OP_SHL  = 3'b010,
    OP_XOR  = 3'b011,
    OP_ROL  = 3'b100,
    OP_AND  = 3'b101,
    OP_MUL  = 3'b110,
    OP_ADD  = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } alu_state_e;

endpackage

// File: rtl/alu_mul_iter.sv
// alu_mul_iter: iterative unsigned shift-add multiplier, one partial
// product per cycle.
//   clk, rst_n - clock, async active-low reset
//   start      - capture a/b and fold in the first partial product
//   a, b       - W-bit unsigned operands
//   done       - high once all W partial products are accumulated;
//                stays high until the next start
//   prod       - 2W-bit product (valid while done=1)
module alu_mul_iter
  import alu_pkg::*;
#(
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           done,
  output logic [2*W-1:0] prod
);

  localparam int CW = $clog2(W) + 1;

  logic [CW-1:0]  cnt;
  logic [2*W-1:0] acc;
  logic [2*W-1:0] a_sh;
  logic [W-1:0]   b_sh;

  // Bit 0 of b is consumed on the start edge, so the counter reaches W
  // after W-1 further cycles. cnt==0 only after reset (idle).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      acc  <= '0;
      a_sh <= '0;
      b_sh <= '0;
    end else if (start) begin
      acc  <= b[0] ? {{W{1'b0}}, a} : '0;
      a_sh <= {{(W-1){1'b0}}, a, 1'b0};
      b_sh <= {1'b0, b[W-1:1]};
      cnt  <= CW'(1);
    end else if (cnt != '0 && cnt != CW'(W)) begin
      if (b_sh[0]) acc <= acc + a_sh;
      a_sh <= {a_sh[2*W-2:0], 1'b0};
      b_sh <= {1'b0, b_sh[W-1:1]};
      cnt  <= cnt + CW'(1);
    end
  end

  assign done = (cnt == CW'(W));
  assign prod = acc;

endmodule

// File: rtl/alu_seq.sv
// alu_seq: handshaked ALU with registered result and flags.
//   clk, rst_n            - clock, async active-low reset
//   in_valid / in_ready   - operation handshake (accept = both high)
//   alu_cmd, inA, inB     - opcode and W-bit operands, captured at accept
//   sc_i                  - shift-in bit for SHL
//   out_valid / out_ready - result handshake
//   rslt, rslt_hi         - result (rslt_hi only non-zero for MUL)
//   sc_o, pari, zero      - carry/borrow/shift-out, parity of rslt, all-zero
// Build option: define ALU_MUL_EN to implement the W-cycle iterative MUL.
// Without it opcode 110 completes in one cycle with an all-zero result.
// Legal W: 8, 16, 32.
module alu_seq
  import alu_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [2:0]   alu_cmd,
  input  logic [W-1:0] inA,
  input  logic [W-1:0] inB,
  input  logic         sc_i,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] rslt,
  output logic [W-1:0] rslt_hi,
  output logic         sc_o,
  output logic         pari,
  output logic         zero
);

  localparam int AW = $clog2(W);

  alu_state_e     st, nxt;
  alu_op_e        op;
  logic           accept;
  logic           is_mul;
  logic           load_alu, load_mul;
  logic           mul_done;
  logic [2*W-1:0] mul_prod;

  logic [W-1:0]   res;
  logic           res_c;
  logic [W:0]     add_x, sub_x;
  logic [2*W-1:0] rot;

  assign op       = alu_op_e'(alu_cmd);
  assign in_ready = (st == IDLE) || (st == DONE && out_ready);
  assign accept   = in_valid & in_ready;
  assign out_valid = (st == DONE);

  // ---------------- single-cycle datapath ----------------
  assign add_x = {1'b0, inA} + {1'b0, inB};
  assign sub_x = {1'b0, inA} - {1'b0, inB};
  // Rotate via a doubled word: the upper half of {A,A}<<n is A rotl n,
  // and n=0 naturally returns A.
  assign rot   = {inA, inA} << inB[AW-1:0];

  always_comb begin
    res   = '0;
    res_c = 1'b0;
    case (op)
      OP_PASS: res = inA;
      OP_SUB:  {res_c, res} = sub_x;
      OP_SHL:  begin res = {inA[W-2:0], sc_i}; res_c = inA[W-1]; end
      OP_XOR:  res = inA ^ inB;
      OP_ROL:  res = rot[2*W-1:W];
      OP_AND:  res = inA & inB;
      OP_ADD:  {res_c, res} = add_x;
      default: res = '0;  // MUL when the multiplier is not built
    endcase
  end

  // ---------------- multiplier ----------------
`ifdef ALU_MUL_EN
  logic mul_start;
  assign is_mul    = (op == OP_MUL);
  assign mul_start = accept & is_mul;

  alu_mul_iter #(.W(W)) u_mul (
    .clk   (clk),
    .rst_n (rst_n),
    .start (mul_start),
    .a     (inA),
    .b     (inB),
    .done  (mul_done),
    .prod  (mul_prod)
  );
`else
  assign is_mul   = 1'b0;
  assign mul_done = 1'b0;
  assign mul_prod = '0;
`endif

  // ---------------- control FSM ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) st <= IDLE;
    else        st <= nxt;
  end

  always_comb begin
    nxt      = st;
    load_alu = 1'b0;
    load_mul = 1'b0;
    case (st)
      IDLE, DONE: begin
        if (accept) begin
          if (is_mul) nxt = BUSY;
          else begin
            nxt      = DONE;
            load_alu = 1'b1;
          end
        end else if (st == DONE && out_ready) begin
          nxt = IDLE;
        end
      end
      BUSY: begin
        if (mul_done) begin
          nxt      = DONE;
          load_mul = 1'b1;
        end
      end
      default: nxt = IDLE;
    endcase
  end

  // ---------------- result / flag registers ----------------
  // Only written on a load, so they hold while a result is stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rslt    <= '0;
      rslt_hi <= '0;
      sc_o    <= 1'b0;
      pari    <= 1'b0;
      zero    <= 1'b1;
    end else if (load_alu) begin
      rslt    <= res;
      rslt_hi <= '0;
      sc_o    <= res_c;
      pari    <= ^res;
      zero    <= (res == '0);
    end else if (load_mul) begin
      rslt    <= mul_prod[W-1:0];
      rslt_hi <= mul_prod[2*W-1:W];
      sc_o    <= 1'b0;
      pari    <= ^mul_prod[W-1:0];
      zero    <= (mul_prod == '0);
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed self-checking bench for alu_seq (W=8).
// MUL checks are compiled when ALU_MUL_EN is defined; otherwise the
// disabled-MUL behaviour of opcode 110 is checked.
module tb_alu_seq;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [2:0]   alu_cmd;
  logic [W-1:0] inA, inB;
  logic         sc_i;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] rslt, rslt_hi;
  logic         sc_o, pari, zero;

  int n_chk  = 0;
  int n_fail = 0;

  alu_seq #(.W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alu_cmd   (alu_cmd),
    .inA       (inA),
    .inB       (inB),
    .sc_i      (sc_i),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .rslt      (rslt),
    .rslt_hi   (rslt_hi),
    .sc_o      (sc_o),
    .pari      (pari),
    .zero      (zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] c, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic s);
    alu_cmd  = c;
    inA      = a;
    inB      = b;
    sc_i     = s;
    in_valid = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    alu_cmd = '0; inA = '0; inB = '0; sc_i = 1'b0;
    #12;
    check("rst_in_ready",  in_ready,  1);
    check("rst_out_valid", out_valid, 0);
    check("rst_rslt",      rslt,      0);
    check("rst_rslt_hi",   rslt_hi,   0);
    check("rst_sc_o",      sc_o,      0);
    check("rst_pari",      pari,      0);
    check("rst_zero",      zero,      1);
    rst_n = 1'b1;
    tick();

    // ADD F0+20, sc_i ignored
    drive(3'b111, 8'hF0, 8'h20, 1'b1);
    #1 check("add_pre_valid", out_valid, 0);
    tick(); in_valid = 1'b0;
    check("add_valid",   out_valid, 1);
    check("add_rslt",    rslt,      8'h10);
    check("add_hi",      rslt_hi,   0);
    check("add_sc",      sc_o,      1);
    check("add_zero",    zero,      0);
    check("add_pari",    pari,      1);
    tick();
    check("add_drop",    out_valid, 0);
    check("idle_ready",  in_ready,  1);

    // ROL back-to-back: by 1, by 9, by 0
    drive(3'b100, 8'h81, 8'd1, 1'b0);
    tick();
    check("rol1_rslt", rslt, 8'h03);
    check("rol1_sc",   sc_o, 0);
    check("b2b_ready", in_ready, 1);
    drive(3'b100, 8'h81, 8'd9, 1'b1);
    tick();
    check("rol9_rslt",  rslt, 8'h03);
    check("rol9_sc",    sc_o, 0);
    check("rol9_valid", out_valid, 1);
    drive(3'b100, 8'h81, 8'd0, 1'b0);
    tick(); in_valid = 1'b0;
    check("rol0_rslt", rslt, 8'h81);
    check("rol0_sc",   sc_o, 0);
    check("rol0_pari", pari, 0);
    tick();

    // SUB 05-07 borrows
    drive(3'b001, 8'h05, 8'h07, 1'b0);
    tick(); in_valid = 1'b0;
    check("sub_rslt", rslt, 8'hFE);
    check("sub_sc",   sc_o, 1);
    check("sub_pari", pari, 1);

    // SHL 80 with sc_i=1
    drive(3'b010, 8'h80, 8'h00, 1'b1);
    tick(); in_valid = 1'b0;
    check("shl_rslt", rslt, 8'h01);
    check("shl_sc",   sc_o, 1);

    // PASS 00 -> zero flag from result
    drive(3'b000, 8'h00, 8'h5A, 1'b1);
    tick(); in_valid = 1'b0;
    check("pass_rslt", rslt, 8'h00);
    check("pass_zero", zero, 1);
    check("pass_sc",   sc_o, 0);
    tick();

    // Backpressure: XOR held for 3 cycles while an AND waits
    out_ready = 1'b0;
    drive(3'b011, 8'hAA, 8'h0F, 1'b0);
    tick();
    drive(3'b101, 8'hF0, 8'h3C, 1'b0);
    for (int k = 0; k < 3; k++) begin
      check("bp_valid", out_valid, 1);
      check("bp_rslt",  rslt,      8'hA5);
      check("bp_ready", in_ready,  0);
      check("bp_pari",  pari,      0);
      tick();
    end
    out_ready = 1'b1;
    #1 check("bp_release_ready", in_ready, 1);
    tick(); in_valid = 1'b0;
    check("and_valid", out_valid, 1);
    check("and_rslt",  rslt,      8'h30);
    tick();
    check("and_drop",  out_valid, 0);

`ifdef ALU_MUL_EN
    // MUL FF*FF = FE01, W cycles busy
    drive(3'b110, 8'hFF, 8'hFF, 1'b0);
    tick(); in_valid = 1'b0;
    inA = 8'h00; inB = 8'h00;  // later input changes must not matter
    for (int k = 0; k < W - 1; k++) begin
      check("mul_busy_valid", out_valid, 0);
      check("mul_busy_ready", in_ready,  0);
      tick();
    end
    check("mul_last_ready", in_ready, 0);
    tick();
    check("mul_valid", out_valid, 1);
    check("mul_lo",    rslt,      8'h01);
    check("mul_hi",    rslt_hi,   8'hFE);
    check("mul_sc",    sc_o,      0);
    check("mul_zero",  zero,      0);
    check("mul_pari",  pari,      1);
    tick();

    // Reset mid-MUL
    drive(3'b110, 8'h12, 8'h34, 1'b0);
    tick(); in_valid = 1'b0;
    tick(); tick();
    rst_n = 1'b0;
    #1;
`else
    // Disabled MUL: one-cycle, all-zero result
    drive(3'b110, 8'hFF, 8'hFF, 1'b1);
    tick(); in_valid = 1'b0;
    check("mul_off_valid", out_valid, 1);
    check("mul_off_lo",    rslt,      0);
    check("mul_off_hi",    rslt_hi,   0);
    check("mul_off_sc",    sc_o,      0);
    check("mul_off_zero",  zero,      1);
    check("mul_off_pari",  pari,      0);
    tick();

    // Reset while a result is stalled
    out_ready = 1'b0;
    drive(3'b011, 8'h3C, 8'h00, 1'b0);
    tick(); in_valid = 1'b0;
    check("pre_rst_rslt", rslt, 8'h3C);
    rst_n = 1'b0;
    #1;
    out_ready = 1'b1;
`endif
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_rslt",  rslt,      0);
    check("mid_rst_hi",    rslt_hi,   0);
    check("mid_rst_zero",  zero,      1);
    check("mid_rst_ready", in_ready,  1);
    tick();
    rst_n = 1'b1;
    tick();
    check("post_rst_ready", in_ready, 1);
    drive(3'b111, 8'h01, 8'h02, 1'b0);
    tick(); in_valid = 1'b0;
    check("post_add_valid", out_valid, 1);
    check("post_add_rslt",  rslt,      8'h03);
    check("post_add_sc",    sc_o,      0);
    check("post_add_pari",  pari,      0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
